axi_lite_master_bridge: RTL and testbench

- Converts a simple single-beat register-access command stream into AXI4-Lite master transactions.
- Sits directly upstream of the team's AXI-Lite register slave and drives its S_AXI_* channels.
- Returns one response per command: read data or write acknowledgement, plus RESP code.
- Performs a local address-range check and a watchdog on slave handshakes.

---
 rtl/axi_lite_master_bridge_if.sv | 43 ++++
 rtl/axi_lite_master_bridge.sv | 100 ++++++++++
 tb/tb_axi_lite_master_bridge.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_bridge_if.sv
// axi_lite_master_bridge_if: command/response stream plus AXI4-Lite master channels of the bridge
interface axi_lite_master_bridge_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
);
  logic                            CMD_VALID, CMD_READY, CMD_WR;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR;
  logic [C_M_AXI_DATA_WIDTH-1:0]   CMD_WDATA;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB;
  logic                            RSP_VALID, RSP_READY, RSP_WR;
  logic [C_M_AXI_DATA_WIDTH-1:0]   RSP_RDATA;
  logic [1:0]                      RSP_RESP;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]                      M_AXI_AWPROT;
  logic                            M_AXI_AWVALID, M_AXI_AWREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                            M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]                      M_AXI_BRESP;
  logic                            M_AXI_BVALID, M_AXI_BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]                      M_AXI_ARPROT;
  logic                            M_AXI_ARVALID, M_AXI_ARREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]                      M_AXI_RRESP;
  logic                            M_AXI_RVALID, M_AXI_RREADY;
  modport master (
    input  CMD_VALID, CMD_WR, CMD_ADDR, CMD_WDATA, CMD_WSTRB, RSP_READY,
           M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output CMD_READY, RSP_VALID, RSP_WR, RSP_RDATA, RSP_RESP,
           M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY
  );
  modport slave (
    output CMD_VALID, CMD_WR, CMD_ADDR, CMD_WDATA, CMD_WSTRB, RSP_READY,
           M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  CMD_READY, RSP_VALID, RSP_WR, RSP_RDATA, RSP_RESP,
           M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge: single-beat command stream to AXI4-Lite master, with range check and handshake watchdog
module axi_lite_master_bridge #(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] C_TARGET_BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] C_TARGET_HIGH_ADDR = 32'h0000_FFFF,
  parameter int          C_TIMEOUT_CYCLES   = 256
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  axi_lite_master_bridge_if.master        bus,
  output logic                            TIMEOUT_ERR
);
  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int DW  = C_M_AXI_DATA_WIDTH;
  localparam int LSB = $clog2(DW / 8);
  localparam int CW  = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] base_addr = AW'(C_TARGET_BASE_ADDR);
  localparam logic [AW-1:0] span      = AW'(C_TARGET_HIGH_ADDR - C_TARGET_BASE_ADDR);
  localparam logic [CW-1:0] limit     = CW'(C_TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;
  state_t          state, state_nx;
  logic            aw_pend, w_pend, cmd_ok, wait_st, rsp_wr;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      resp;
  logic [CW-1:0]   cnt, cnt_nx;
  // offset compare covers both bounds without a constant-true check when the base is zero
  assign cmd_ok  = ((bus.CMD_ADDR - base_addr) <= span) && (bus.CMD_ADDR[LSB-1:0] == '0);
  assign wait_st = state inside {WR, WB, RA, RD};
  always_ff @(posedge ACLK)
    state <= ARESET ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !bus.CMD_VALID ? IDLE : !cmd_ok ? RSP : bus.CMD_WR ? WR : RA;
      WR:      state_nx = ((!aw_pend || bus.M_AXI_AWREADY) && (!w_pend || bus.M_AXI_WREADY)) ? WB : WR;
      WB:      state_nx = bus.M_AXI_BVALID ? RSP : WB;
      RA:      state_nx = bus.M_AXI_ARREADY ? RD : RA;
      RD:      state_nx = bus.M_AXI_RVALID ? RSP : RD;
      RSP:     state_nx = bus.RSP_READY ? IDLE : RSP;
      default: state_nx = IDLE;
    endcase
    cnt_nx = (state_nx != state) ? '0 : (wait_st && cnt != limit) ? cnt + 1'b1 : cnt;
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      wstrb       <= '0;
      rdata       <= '0;
      resp        <= 2'b00;
      rsp_wr      <= 1'b0;
      cnt         <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      cnt         <= cnt_nx;
      TIMEOUT_ERR <= TIMEOUT_ERR || (cnt_nx == limit);
      if (state == IDLE && bus.CMD_VALID) begin
        addr    <= bus.CMD_ADDR;
        wdata   <= bus.CMD_WDATA;
        wstrb   <= bus.CMD_WSTRB;
        rsp_wr  <= bus.CMD_WR;
        aw_pend <= cmd_ok && bus.CMD_WR;
        w_pend  <= cmd_ok && bus.CMD_WR;
        rdata   <= '0;
        resp    <= cmd_ok ? 2'b00 : 2'b11;
      end
      if (state == WR && bus.M_AXI_AWREADY) aw_pend <= 1'b0;
      if (state == WR && bus.M_AXI_WREADY) w_pend <= 1'b0;
      if (state == WB && bus.M_AXI_BVALID) begin
        resp  <= bus.M_AXI_BRESP;
        rdata <= '0;
      end
      if (state == RD && bus.M_AXI_RVALID) begin
        resp  <= bus.M_AXI_RRESP;
        rdata <= bus.M_AXI_RDATA;
      end
    end
  end
  assign bus.CMD_READY     = state == IDLE;
  assign bus.RSP_VALID     = state == RSP;
  assign bus.RSP_WR        = rsp_wr;
  assign bus.RSP_RDATA     = rdata;
  assign bus.RSP_RESP      = resp;
  assign bus.M_AXI_AWADDR  = addr;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_AWVALID = state == WR && aw_pend;
  assign bus.M_AXI_WDATA   = wdata;
  assign bus.M_AXI_WSTRB   = wstrb;
  assign bus.M_AXI_WVALID  = state == WR && w_pend;
  assign bus.M_AXI_BREADY  = state == WB;
  assign bus.M_AXI_ARADDR  = addr;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_ARVALID = state == RA;
  assign bus.M_AXI_RREADY  = state == RD;
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// tb_axi_lite_master_bridge: directed and random commands against a memory-array reference model and an AXI slave model
module tb_axi_lite_master_bridge;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic TIMEOUT_ERR;
  always #5 ACLK = ~ACLK;
  axi_lite_master_bridge_if #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)) bus ();
  axi_lite_master_bridge #(.C_TIMEOUT_CYCLES(256)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus), .TIMEOUT_ERR(TIMEOUT_ERR)
  );
  int n_chk = 0, n_err = 0, cyc = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // slave model state
  logic [31:0] smem [0:16383];
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  int aw_beats = 0, w_beats = 0, ar_beats = 0, aw_hs = 0, w_hs = 0, done_hs = 0;
  int aw_w = 0, w_w = 0, ar_w = 0, b_w = 0, r_w = 0;
  bit aw_have = 0, w_have = 0, b_pend = 0, r_pend = 0, aw_hold = 0, w_hold = 0, ar_hold = 0;
  logic [31:0] aw_addr_q, ar_addr_q, w_data_q, r_data_q, aw_hold_a, ar_hold_a, w_hold_d;
  logic [3:0] w_strb_q, w_hold_s;
  logic [1:0] b_resp_q, r_resp_q;
  initial begin
    for (int i = 0; i < 16384; i++) smem[i] = '0;
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
    bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0; bus.M_AXI_RVALID = 0;
    bus.M_AXI_RDATA = 0; bus.M_AXI_RRESP = 0;
    forever begin
      @(posedge ACLK);
      cyc++;
      if (ARESET) begin
        aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0;
      end else begin
        if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
          aw_beats++; aw_hs = cyc; aw_addr_q = bus.M_AXI_AWADDR; aw_have = 1;
          chk("awprot", bus.M_AXI_AWPROT, 3'b000);
        end
        if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
          w_beats++; w_hs = cyc; w_data_q = bus.M_AXI_WDATA; w_strb_q = bus.M_AXI_WSTRB; w_have = 1;
        end
        if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin b_pend = 0; done_hs = cyc; end
        if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) begin r_pend = 0; done_hs = cyc; end
        if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
          ar_beats++; ar_addr_q = bus.M_AXI_ARADDR; r_pend = 1;
          r_data_q = smem[ar_addr_q[15:2]];
          r_resp_q = ar_addr_q[15:12] == 4'hF ? 2'b10 : 2'b00;
          chk("arprot", bus.M_AXI_ARPROT, 3'b000);
        end
        if (aw_have && w_have) begin
          if (aw_addr_q[15:12] != 4'hF)
            for (int i = 0; i < 4; i++)
              if (w_strb_q[i]) smem[aw_addr_q[15:2]][8*i +: 8] = w_data_q[8*i +: 8];
          b_resp_q = aw_addr_q[15:12] == 4'hF ? 2'b10 : 2'b00;
          b_pend = 1; aw_have = 0; w_have = 0;
        end
      end
      @(negedge ACLK);
      if (aw_hold) begin chk("awvalid_held", bus.M_AXI_AWVALID, 1'b1); chk("awaddr_stable", bus.M_AXI_AWADDR, aw_hold_a); end
      if (w_hold) begin chk("wvalid_held", bus.M_AXI_WVALID, 1'b1); chk("wdata_stable", {bus.M_AXI_WSTRB, bus.M_AXI_WDATA}, {w_hold_s, w_hold_d}); end
      if (ar_hold) begin chk("arvalid_held", bus.M_AXI_ARVALID, 1'b1); chk("araddr_stable", bus.M_AXI_ARADDR, ar_hold_a); end
      bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && aw_w >= aw_dly;
      bus.M_AXI_WREADY  = bus.M_AXI_WVALID && w_w >= w_dly;
      bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && ar_w >= ar_dly;
      aw_w = bus.M_AXI_AWVALID ? aw_w + 1 : 0;
      w_w  = bus.M_AXI_WVALID ? w_w + 1 : 0;
      ar_w = bus.M_AXI_ARVALID ? ar_w + 1 : 0;
      aw_hold = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY; aw_hold_a = bus.M_AXI_AWADDR;
      w_hold  = bus.M_AXI_WVALID && !bus.M_AXI_WREADY;   w_hold_d = bus.M_AXI_WDATA; w_hold_s = bus.M_AXI_WSTRB;
      ar_hold = bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY; ar_hold_a = bus.M_AXI_ARADDR;
      if (b_pend) begin if (b_w >= b_dly) bus.M_AXI_BVALID = 1; else b_w++; end
      else begin bus.M_AXI_BVALID = 0; b_w = 0; end
      bus.M_AXI_BRESP = b_resp_q;
      if (r_pend) begin if (r_w >= r_dly) bus.M_AXI_RVALID = 1; else r_w++; end
      else begin bus.M_AXI_RVALID = 0; r_w = 0; end
      bus.M_AXI_RDATA = bus.M_AXI_RVALID ? r_data_q : $urandom;
      bus.M_AXI_RRESP = bus.M_AXI_RVALID ? r_resp_q : 2'($urandom);
    end
  end
  // reference model: expected outcome of each command from address rules and a word array
  logic [31:0] ref_mem [0:16383];
  logic        e_wr, e_ok;
  logic [31:0] e_addr, e_data, e_rdata;
  logic [3:0]  e_strb;
  logic [1:0]  e_resp;
  int e_aw0, e_w0, e_ar0;
  function automatic logic [1:0] ref_resp(input logic [31:0] a);
    if (a > 32'h0000_FFFF || a[1:0] != 2'b00) return 2'b11;
    return a[15:12] == 4'hF ? 2'b10 : 2'b00;
  endfunction
  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, bus.CMD_READY, 1'b1);
    chk({tag, "_valids"}, {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID, bus.M_AXI_BREADY, bus.M_AXI_RREADY, bus.RSP_VALID}, 6'b0);
    chk({tag, "_rsp"}, {bus.RSP_WR, bus.RSP_RESP, bus.RSP_RDATA}, 35'b0);
    chk({tag, "_addr"}, {bus.M_AXI_AWADDR, bus.M_AXI_ARADDR}, 64'b0);
    chk({tag, "_wdata"}, {bus.M_AXI_WSTRB, bus.M_AXI_WDATA}, 36'b0);
    chk({tag, "_timeout"}, TIMEOUT_ERR, 1'b0);
  endtask
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    while (!bus.CMD_READY && n < 1000) begin @(negedge ACLK); n++; end
    chk("cmd_ready_wait", bus.CMD_READY, 1'b1);
    e_wr = wr; e_addr = a; e_data = d; e_strb = s;
    e_resp = ref_resp(a); e_ok = e_resp != 2'b11;
    e_aw0 = aw_beats; e_w0 = w_beats; e_ar0 = ar_beats;
    if (wr) begin
      e_rdata = '0;
      if (e_resp == 2'b00)
        for (int i = 0; i < 4; i++) if (s[i]) ref_mem[a[15:2]][8*i +: 8] = d[8*i +: 8];
    end else e_rdata = e_ok ? ref_mem[a[15:2]] : '0;
    bus.CMD_VALID = 1; bus.CMD_WR = wr; bus.CMD_ADDR = a; bus.CMD_WDATA = d; bus.CMD_WSTRB = s;
    @(negedge ACLK);
    bus.CMD_VALID = 0; bus.CMD_ADDR = $urandom; bus.CMD_WDATA = $urandom; bus.CMD_WSTRB = 4'($urandom);
    chk("awvalid_lat", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID}, {2{wr && e_ok}});
    chk("arvalid_lat", bus.M_AXI_ARVALID, !wr && e_ok);
    chk("rsp_valid_lat", bus.RSP_VALID, !e_ok);
    chk("cmd_ready_busy", bus.CMD_READY, 1'b0);
  endtask
  task automatic complete(input int hold);
    int n;
    n = 0;
    while (!bus.RSP_VALID && n < 2000) begin @(negedge ACLK); n++; end
    chk("rsp_seen", bus.RSP_VALID, 1'b1);
    if (e_ok) chk("rsp_latency", 64'(cyc - done_hs), 64'd0);
    chk("rsp_wr", bus.RSP_WR, e_wr);
    chk("rsp_rdata", bus.RSP_RDATA, e_rdata);
    chk("rsp_resp", bus.RSP_RESP, e_resp);
    chk("aw_beats", 64'(aw_beats - e_aw0), 64'(e_wr && e_ok));
    chk("w_beats", 64'(w_beats - e_w0), 64'(e_wr && e_ok));
    chk("ar_beats", 64'(ar_beats - e_ar0), 64'(!e_wr && e_ok));
    if (e_wr && e_ok) chk("aw_w_payload", {aw_addr_q, w_data_q, w_strb_q}, {e_addr, e_data, e_strb});
    if (!e_wr && e_ok) chk("araddr", ar_addr_q, e_addr);
    for (int i = 0; i < hold; i++) begin
      bus.RSP_READY = 0;
      bus.CMD_VALID = 1; bus.CMD_WR = 0; bus.CMD_ADDR = 32'h8;
      @(negedge ACLK);
      chk("hold_valid", bus.RSP_VALID, 1'b1);
      chk("hold_fields", {bus.RSP_WR, bus.RSP_RESP, bus.RSP_RDATA}, {e_wr, e_resp, e_rdata});
      chk("hold_no_accept", {bus.CMD_READY, bus.M_AXI_AWVALID, bus.M_AXI_ARVALID}, 3'b000);
    end
    bus.CMD_VALID = 0;
    bus.RSP_READY = 1;
    @(negedge ACLK);
    bus.RSP_READY = 0;
    chk("rsp_dropped", bus.RSP_VALID, 1'b0);
    chk("idle_after_rsp", bus.CMD_READY, 1'b1);
    chk("hold_beats", 64'(ar_beats - e_ar0), 64'(!e_wr && e_ok));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation did not terminate");
  end
  initial begin
    logic        wr;
    logic [31:0] a, d;
    logic [3:0]  s;
    int          sel, n;
    for (int i = 0; i < 16384; i++) ref_mem[i] = '0;
    bus.CMD_VALID = 0; bus.CMD_WR = 0; bus.CMD_ADDR = 0; bus.CMD_WDATA = 0; bus.CMD_WSTRB = 0; bus.RSP_READY = 0;
    repeat (3) @(negedge ACLK);
    check_reset_vals("reset");
    ARESET = 0;
    @(negedge ACLK);
    aw_dly = 0; w_dly = 0; b_dly = 0;
    issue(1, 32'h4, 32'hDEAD_BEEF, 4'hF); complete(0);
    chk("aw_w_same_cycle", 64'(w_hs - aw_hs), 64'd0);
    ar_dly = 1; r_dly = 2;
    issue(0, 32'h4, 0, 0); complete(0);
    aw_dly = 0; w_dly = 3; b_dly = 1;
    issue(1, 32'h8, 32'h1234_5678, 4'h5); complete(0);
    chk("w_after_aw", 64'(w_hs - aw_hs), 64'd3);
    issue(1, 32'h0001_0000, 32'h1111_1111, 4'hF); complete(5);
    issue(0, 32'h0000_0002, 0, 0); complete(0);
    issue(1, 32'h0000_F004, 32'h5555_AAAA, 4'hF); complete(2);
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) << 2;
      if (sel == 7) a = a | 32'($urandom_range(1, 3));
      if (sel == 8) a = 32'h0000_F000 | (32'($urandom_range(0, 3)) << 2);
      if (sel == 9) a = $urandom;
      wr = 1'($urandom_range(0, 1)); d = $urandom; s = 4'($urandom_range(0, 15));
      aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4); ar_dly = $urandom_range(0, 4);
      b_dly = $urandom_range(0, 4); r_dly = $urandom_range(0, 4);
      issue(wr, a, d, s); complete($urandom_range(0, 3));
    end
    chk("no_early_timeout", TIMEOUT_ERR, 1'b0);
    ar_dly = 300; r_dly = 0;
    issue(0, 32'h4, 0, 0);
    repeat (255) @(negedge ACLK);
    chk("timeout_before", TIMEOUT_ERR, 1'b0);
    @(negedge ACLK);
    chk("timeout_set", TIMEOUT_ERR, 1'b1);
    chk("timeout_arvalid", bus.M_AXI_ARVALID, 1'b1);
    complete(0);
    chk("timeout_sticky", TIMEOUT_ERR, 1'b1);
    ar_dly = 0; r_dly = 20;
    issue(0, 32'h8, 0, 0);
    n = 0;
    while (!bus.M_AXI_RREADY && n < 100) begin @(negedge ACLK); n++; end
    chk("reached_rd", bus.M_AXI_RREADY, 1'b1);
    ARESET = 1;
    @(negedge ACLK);
    ARESET = 0;
    check_reset_vals("mid_reset");
    r_dly = 1;
    issue(0, 32'h8, 0, 0); complete(1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
